interfere_pcs_hss_checker: RTL and testbench

Receive-side companion to the PCS→HSS error/loss injector in the fake HSS bench. It sits on the injector output and holds a delayed copy of the injector input. Each received word is classified as good, bit-errored or lost. The block keeps saturating statistics and runs a link-health state machine, so benches can check injected error rates and PCS recovery behaviour without trusting the injector's own log output.

---
 rtl/interfere_pcs_hss_checker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_interfere_pcs_hss_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/interfere_pcs_hss_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// interfere_pcs_hss_checker
//
// Receive-side checker for the PCS->HSS error/loss injector. A delayed copy
// of the injector input (Ref) is lined up against the injector output (Rx).
// Each valid word is classified as good, bit-errored or lost. Saturating
// statistics are kept, and a link-health state machine runs
// (INIT / LOCKED / DEGRADED).
//
// Parameters:
//   DW          PCS word width (matches injector data width)
//   LATENCY     injector pipeline depth in cycles, legal range 1..8
//   BAD_THRESH  consecutive bad words that drop LOCKED -> DEGRADED
//   GOOD_THRESH consecutive good words that reach / regain LOCKED
//
// Ports:
//   clk         clock, all state on rising edge
//   Rst_n       synchronous active-low reset
//   Ref_vld     Ref carries a word presented to the injector this cycle
//   Ref         injector input word
//   Rx          injector output word
//   Clr         synchronous clear of the statistics counters
//   Good_pulse  one cycle: compared word matched
//   Err_pulse   one cycle: compared word was bit-errored
//   Lost_pulse  one cycle: compared word was lost (Rx all zero)
//   Link_ok     high only in LOCKED
//   Link_state  00 INIT, 01 LOCKED, 10 DEGRADED
//   Word_cnt    compared words (saturating)
//   Err_cnt     bit-errored words (saturating)
//   Lost_cnt    lost words (saturating)
//   Bit_cnt     flipped bits summed over bit-errored words (saturating)
//   Drop_cnt    LOCKED -> DEGRADED transitions (saturating)
// ---------------------------------------------------------------------------
module interfere_pcs_hss_checker #(
    parameter int DW          = 66,
    parameter int LATENCY     = 1,
    parameter int BAD_THRESH  = 4,
    parameter int GOOD_THRESH = 16
) (
    input  logic          clk,
    input  logic          Rst_n,
    input  logic          Ref_vld,
    input  logic [DW-1:0] Ref,
    input  logic [DW-1:0] Rx,
    input  logic          Clr,
    output logic          Good_pulse,
    output logic          Err_pulse,
    output logic          Lost_pulse,
    output logic          Link_ok,
    output logic [1:0]    Link_state,
    output logic [31:0]   Word_cnt,
    output logic [15:0]   Err_cnt,
    output logic [15:0]   Lost_cnt,
    output logic [31:0]   Bit_cnt,
    output logic [7:0]    Drop_cnt
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_DEGRADED = 2'b10
    } link_state_t;

    localparam int GW = $clog2(GOOD_THRESH + 1);
    localparam int BW = $clog2(BAD_THRESH + 1);
    localparam int PW = $clog2(DW + 1);

    localparam logic [GW-1:0] GOOD_MAX = GW'(GOOD_THRESH);
    localparam logic [BW-1:0] BAD_MAX  = BW'(BAD_THRESH);

    // ------------------------------------------------------------------
    // Saturation and bit-count helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == '1) ? a : a + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == '1) ? a : a + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == '1) ? a : a + 8'd1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [DW-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Delay line: stage LATENCY-1 output is aligned with the current Rx
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] dly_vld;
    logic [DW-1:0]      dly_data [LATENCY];

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            dly_vld <= '0;
        end else begin
            dly_vld[0] <= Ref_vld;
            for (int i = 1; i < LATENCY; i++) begin
                dly_vld[i] <= dly_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dly_data[0] <= Ref;
        for (int i = 1; i < LATENCY; i++) begin
            dly_data[i] <= dly_data[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage p0: Rx captured together with its aligned reference word
    // ------------------------------------------------------------------
    logic          vld_p0;
    logic [DW-1:0] rx_p0;
    logic [DW-1:0] ref_p0;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= dly_vld[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        rx_p0  <= Rx;
        ref_p0 <= dly_data[LATENCY-1];
    end

    // Classification of the p0 word. Lost implies a mismatch, so the three
    // outcomes are mutually exclusive by construction.
    logic [DW-1:0] diff_p0;
    logic [PW-1:0] flips_p0;
    logic          is_good;
    logic          is_lost;
    logic          is_err;
    logic          is_bad;

    always_comb begin
        diff_p0  = rx_p0 ^ ref_p0;
        flips_p0 = popcount(diff_p0);
        is_good  = vld_p0 && (diff_p0 == '0);
        is_lost  = vld_p0 && (rx_p0 == '0) && (ref_p0 != '0);
        is_err   = vld_p0 && (diff_p0 != '0) && !is_lost;
        is_bad   = is_err || is_lost;
    end

    // ------------------------------------------------------------------
    // Link-health state machine and run-length counters
    // ------------------------------------------------------------------
    link_state_t   state;
    link_state_t   state_next;
    logic [GW-1:0] good_run;
    logic [GW-1:0] good_run_next;
    logic [BW-1:0] bad_run;
    logic [BW-1:0] bad_run_next;
    logic          drop_evt;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state    <= ST_INIT;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state    <= state_next;
            good_run <= good_run_next;
            bad_run  <= bad_run_next;
        end
    end

    always_comb begin
        state_next    = state;
        good_run_next = good_run;
        bad_run_next  = bad_run;
        drop_evt      = 1'b0;

        if (is_good) begin
            good_run_next = (good_run == GOOD_MAX) ? good_run : good_run + GW'(1);
            bad_run_next  = '0;
        end else if (is_bad) begin
            bad_run_next  = (bad_run == BAD_MAX) ? bad_run : bad_run + BW'(1);
            good_run_next = '0;
        end

        // INIT only ever moves to LOCKED; bad words there just reset good_run.
        unique case (state)
            ST_INIT, ST_DEGRADED: begin
                if (is_good && (good_run_next == GOOD_MAX)) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (is_bad && (bad_run_next == BAD_MAX)) begin
                    state_next = ST_DEGRADED;
                    drop_evt   = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // Every transition starts both runs afresh.
        if (state_next != state) begin
            good_run_next = '0;
            bad_run_next  = '0;
        end
    end

    assign Link_state = state;
    assign Link_ok    = (state == ST_LOCKED);

    // ------------------------------------------------------------------
    // Stage p1: pulses and statistics. Clr takes priority over an event
    // landing on the same edge; the pulse is still reported.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            Good_pulse <= 1'b0;
            Err_pulse  <= 1'b0;
            Lost_pulse <= 1'b0;
            Word_cnt   <= '0;
            Err_cnt    <= '0;
            Lost_cnt   <= '0;
            Bit_cnt    <= '0;
            Drop_cnt   <= '0;
        end else begin
            Good_pulse <= is_good;
            Err_pulse  <= is_err;
            Lost_pulse <= is_lost;
            if (Clr) begin
                Word_cnt <= '0;
                Err_cnt  <= '0;
                Lost_cnt <= '0;
                Bit_cnt  <= '0;
                Drop_cnt <= '0;
            end else begin
                if (vld_p0) begin
                    Word_cnt <= sat_inc32(Word_cnt);
                end
                if (is_err) begin
                    Err_cnt <= sat_inc16(Err_cnt);
                    Bit_cnt <= sat_add32(Bit_cnt, 32'(flips_p0));
                end
                if (is_lost) begin
                    Lost_cnt <= sat_inc16(Lost_cnt);
                end
                if (drop_evt) begin
                    Drop_cnt <= sat_inc8(Drop_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_interfere_pcs_hss_checker.sv
`timescale 1ns/1ps
// Self-checking bench for interfere_pcs_hss_checker: a LATENCY=1 instance
// driven from a table of per-word records plus a saturation/Clr sequence,
// and a LATENCY=3 instance used for the mid-stream reset sequence.
module tb_interfere_pcs_hss_checker;

    localparam int DW = 66;

    localparam logic [2:0] P_N = 3'b000;
    localparam logic [2:0] P_G = 3'b100;
    localparam logic [2:0] P_E = 3'b010;
    localparam logic [2:0] P_L = 3'b001;

    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_LOCK = 2'b01;
    localparam logic [1:0] S_DEG  = 2'b10;

    localparam logic [DW-1:0] FLIP3 = 66'h2_0000_0000_0000_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic          rst1_n = 1'b0;
    logic          vld1   = 1'b0;
    logic [DW-1:0] ref1   = '0;
    logic [DW-1:0] rx1    = '0;
    logic          clr1   = 1'b0;
    logic          good1, err1, lost1, ok1;
    logic [1:0]    st1;
    logic [31:0]   words1, bits1;
    logic [15:0]   errc1, lostc1;
    logic [7:0]    drop1;

    interfere_pcs_hss_checker #(.DW(DW), .LATENCY(1), .BAD_THRESH(4), .GOOD_THRESH(16)) dut1 (
        .clk(clk), .Rst_n(rst1_n), .Ref_vld(vld1), .Ref(ref1), .Rx(rx1), .Clr(clr1),
        .Good_pulse(good1), .Err_pulse(err1), .Lost_pulse(lost1), .Link_ok(ok1),
        .Link_state(st1), .Word_cnt(words1), .Err_cnt(errc1), .Lost_cnt(lostc1),
        .Bit_cnt(bits1), .Drop_cnt(drop1)
    );

    // LATENCY=3 instance
    logic          rst3_n = 1'b0;
    logic          vld3   = 1'b0;
    logic [DW-1:0] ref3   = '0;
    logic [DW-1:0] rx3    = '0;
    logic          clr3   = 1'b0;
    logic          good3, err3, lost3, ok3;
    logic [1:0]    st3;
    logic [31:0]   words3, bits3;
    logic [15:0]   errc3, lostc3;
    logic [7:0]    drop3;

    interfere_pcs_hss_checker #(.DW(DW), .LATENCY(3), .BAD_THRESH(4), .GOOD_THRESH(16)) dut3 (
        .clk(clk), .Rst_n(rst3_n), .Ref_vld(vld3), .Ref(ref3), .Rx(rx3), .Clr(clr3),
        .Good_pulse(good3), .Err_pulse(err3), .Lost_pulse(lost3), .Link_ok(ok3),
        .Link_state(st3), .Word_cnt(words3), .Err_cnt(errc3), .Lost_cnt(lostc3),
        .Bit_cnt(bits3), .Drop_cnt(drop3)
    );

    typedef struct {
        logic          vld;
        logic [DW-1:0] ref_w;
        logic [DW-1:0] rx_w;
        logic          clr;
        logic [2:0]    exp_pulse;
        logic [1:0]    exp_state;
        logic [31:0]   exp_words;
        logic [15:0]   exp_err;
        logic [15:0]   exp_lost;
        logic [31:0]   exp_bits;
        logic [7:0]    exp_drop;
    } vec_t;

    vec_t tab[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [DW-1:0] w(input int i);
        return {2'b10, 32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i)};
    endfunction

    task automatic add(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] x,
                       input logic c, input logic [2:0] p, input logic [1:0] s,
                       input int wc, input int ec, input int lc, input int bc, input int dc);
        vec_t e;
        e.vld = v; e.ref_w = r; e.rx_w = x; e.clr = c;
        e.exp_pulse = p; e.exp_state = s;
        e.exp_words = 32'(wc); e.exp_err = 16'(ec); e.exp_lost = 16'(lc);
        e.exp_bits = 32'(bc); e.exp_drop = 8'(dc);
        tab.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Table: words are streamed one per cycle into the LATENCY=1 instance.
        for (int i = 0; i < 20; i++)
            add(1, w(i), w(i), 0, P_G, (i >= 15) ? S_LOCK : S_INIT, i + 1, 0, 0, 0, 0);
        add(1, w(100), w(100) ^ FLIP3, 0, P_E, S_LOCK, 21, 1, 0, 3, 0);
        add(1, w(150), w(150), 0, P_G, S_LOCK, 22, 1, 0, 3, 0);
        for (int i = 0; i < 4; i++)
            add(1, w(200 + i), '0, 0, P_L, (i == 3) ? S_DEG : S_LOCK, 23 + i, 1, i + 1, 3,
                (i == 3) ? 1 : 0);
        for (int i = 0; i < 16; i++)
            add(1, w(300 + i), w(300 + i), 0, P_G, (i == 15) ? S_LOCK : S_DEG, 27 + i, 1, 4, 3, 1);
        add(0, w(400), '0, 0, P_N, S_LOCK, 42, 1, 4, 3, 1);
        add(0, w(401), w(401), 1, P_N, S_LOCK, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0)
                add(1, w(500 + i), w(500 + i) ^ 66'h3, 0, P_E, S_LOCK, i + 1, (i + 2) / 2, 0,
                    2 * ((i + 2) / 2), 0);
            else
                add(1, w(500 + i), w(500 + i), 0, P_G, S_LOCK, i + 1, (i + 2) / 2, 0,
                    2 * ((i + 2) / 2), 0);
        end
        add(1, '0, '0, 0, P_G, S_LOCK, 41, 20, 0, 40, 0);
        add(1, '0, 66'h3, 0, P_E, S_LOCK, 42, 21, 0, 42, 0);

        // Reset state
        cyc();
        cyc();
        check("rst1_state", 0, 32'(st1), 32'(S_INIT));
        check("rst1_pulses", 0, 32'({good1, err1, lost1, ok1}), 32'd0);
        check("rst1_counts", 0, words1 | bits1 | 32'(errc1) | 32'(lostc1) | 32'(drop1), 32'd0);
        check("rst3_state", 0, 32'(st3), 32'(S_INIT));
        check("rst3_counts", 0, words3 | 32'({good3, err3, lost3, ok3}), 32'd0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // Table-driven run on the LATENCY=1 instance
        n = tab.size();
        for (int i = 0; i < n + 2; i++) begin
            vld1 = (i < n) ? tab[i].vld : 1'b0;
            ref1 = (i < n) ? tab[i].ref_w : '0;
            rx1  = (i >= 1 && i - 1 < n) ? tab[i-1].rx_w : '0;
            clr1 = (i >= 2) ? tab[i-2].clr : 1'b0;
            cyc();
            if (i >= 2) begin
                int j;
                j = i - 2;
                check("pulse", j, 32'({good1, err1, lost1}), 32'(tab[j].exp_pulse));
                check("state", j, 32'(st1), 32'(tab[j].exp_state));
                check("link_ok", j, 32'(ok1), 32'(tab[j].exp_state == S_LOCK));
                check("word_cnt", j, words1, tab[j].exp_words);
                check("err_cnt", j, 32'(errc1), 32'(tab[j].exp_err));
                check("lost_cnt", j, 32'(lostc1), 32'(tab[j].exp_lost));
                check("bit_cnt", j, bits1, tab[j].exp_bits);
                check("drop_cnt", j, 32'(drop1), 32'(tab[j].exp_drop));
            end
        end
        clr1 = 1'b0;

        // Err_cnt saturation, then Clr landing on an error event
        clr1 = 1'b1;
        cyc();
        clr1 = 1'b0;
        check("sat_pre_err", 0, 32'(errc1), 32'd0);
        vld1 = 1'b1;
        ref1 = w(7);
        rx1  = w(7) ^ 66'h1;
        repeat (65535) cyc();
        vld1 = 1'b0;
        cyc();
        cyc();
        check("sat_err_full", 0, 32'(errc1), 32'h0000_FFFF);
        check("sat_words", 0, words1, 32'd65535);
        check("sat_bits", 0, bits1, 32'd65535);
        check("sat_state", 0, 32'(st1), 32'(S_DEG));
        check("sat_drop", 0, 32'(drop1), 32'd1);
        vld1 = 1'b1;
        cyc();
        vld1 = 1'b0;
        cyc();
        cyc();
        check("sat_hold_pulse", 0, 32'(err1), 32'd1);
        check("sat_hold_err", 0, 32'(errc1), 32'h0000_FFFF);
        vld1 = 1'b1;
        cyc();
        vld1 = 1'b0;
        cyc();
        clr1 = 1'b1;
        cyc();
        clr1 = 1'b0;
        check("clr_evt_pulse", 0, 32'(err1), 32'd1);
        check("clr_evt_err", 0, 32'(errc1), 32'd0);
        check("clr_evt_words", 0, words1, 32'd0);
        cyc();
        check("pulse_one_cycle", 0, 32'(err1), 32'd0);
        check("after_clr_err", 0, 32'(errc1), 32'd0);

        // LATENCY=3: reset pulsed mid-stream with words in flight
        for (int k = 0; k < 16; k++) begin
            vld3   = 1'b1;
            ref3   = w(600 + k);
            rx3    = (k >= 3) ? w(600 + k - 3) : '0;
            rst3_n = (k != 10);
            cyc();
            if (k == 3) check("l3_no_early", k, 32'({good3, err3, lost3}), 32'd0);
            if (k == 4) check("l3_first_good", k, 32'({good3, err3, lost3}), 32'(P_G));
            if (k == 9) begin
                check("l3_words", k, words3, 32'd6);
                check("l3_good", k, 32'(good3), 32'd1);
            end
            if (k == 10) begin
                check("l3_rst_state", k, 32'(st3), 32'(S_INIT));
                check("l3_rst_out", k, words3 | 32'({good3, err3, lost3, ok3}), 32'd0);
            end
            if (k >= 11 && k <= 14) begin
                check("l3_quiet_pulse", k, 32'({good3, err3, lost3}), 32'd0);
                check("l3_quiet_cnt", k, words3 | bits1 & 32'd0 | 32'(errc3) | 32'(lostc3), 32'd0);
                check("l3_quiet_state", k, 32'(st3), 32'(S_INIT));
            end
            if (k == 15) begin
                check("l3_resume_good", k, 32'(good3), 32'd1);
                check("l3_resume_words", k, words3, 32'd1);
            end
        end
        vld3 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
